// File: rtl/pkt_arb_wrr_avlstrm_pkg.sv
// Shared types and helpers for the packet-atomic weighted round-robin arbiter.
// Optional statistics counters are enabled by defining PKT_ARB_STATS_EN.
package pkt_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Weight that gives an input one packet per turn.
    localparam int unsigned DEFAULT_WEIGHT = 1;

    // Widest requester vector the round-robin helper supports.
    localparam int MAX_IN = 8;

    // Round-robin pick: first requester strictly above ptr, else wrap to the
    // lowest requester (which may be ptr itself). Returns 0 when nothing requests.
    function automatic int rr_pick(input logic [MAX_IN-1:0] req, input int ptr);
        logic [MAX_IN-1:0] hi;
        int                idx_hi;
        int                idx_all;
        for (int i = 0; i < MAX_IN; i++) begin
            hi[i] = req[i] && (i > ptr);
        end
        idx_hi  = 0;
        idx_all = 0;
        for (int i = MAX_IN - 1; i >= 0; i--) begin
            idx_hi  = hi[i]  ? i : idx_hi;
            idx_all = req[i] ? i : idx_all;
        end
        return (|hi) ? idx_hi : idx_all;
    endfunction

endpackage

// File: rtl/pkt_arb_wrr_avlstrm_if.sv
// Avalon-ST bundle: NUM_IN ingress streams plus the shared egress.
// The arbiter connects through the slave modport, the traffic side through master.
interface pkt_arb_wrr_avlstrm_if #(
    parameter int NUM_IN = 4,
    parameter int DW     = 512,
    parameter int EW     = 6
);
    logic [NUM_IN-1:0]    in_valid;
    logic [NUM_IN-1:0]    in_ready;
    logic [NUM_IN*DW-1:0] in_data;
    logic [NUM_IN-1:0]    in_sop;
    logic [NUM_IN-1:0]    in_eop;
    logic [NUM_IN*EW-1:0] in_empty;

    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic                 out_sop;
    logic                 out_eop;
    logic [EW-1:0]        out_empty;
    logic                 out_almostfull;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_empty,
        input  out_ready, out_almostfull,
        output in_ready,
        output out_valid, out_data, out_sop, out_eop, out_empty
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_empty,
        output out_ready, out_almostfull,
        input  in_ready,
        input  out_valid, out_data, out_sop, out_eop, out_empty
    );
endinterface

// File: rtl/pkt_arb_wrr_avlstrm_rr_pick_nxt.sv
// Combinational round-robin search: first requester after ptr, wrapping.
// Usable by any scheduler with up to MAX_IN requesters.
module rr_pick_nxt
    import pkt_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);
    localparam int IW = $clog2(N);

    logic [MAX_IN-1:0] req_pad_s;

    // Widen the request vector to the helper width and run the search
    always_comb begin
        req_pad_s          = {MAX_IN{1'b0}};
        req_pad_s[N-1:0]   = req_i;
        idx_o              = IW'(rr_pick(req_pad_s, int'(ptr_i)));
        found_o            = |req_i;
    end
endmodule

// File: rtl/pkt_arb_wrr_avlstrm.sv
// Packet-atomic weighted round-robin arbiter onto one Avalon-ST egress.
// Each input may send cfg_weight packets per turn; weight 0 disables it.
// Optional per-input packet and sop-error counters: define PKT_ARB_STATS_EN.
module pkt_arb_wrr_avlstrm
    import pkt_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DW     = 512,
    parameter int EW     = 6,
    parameter int WW     = 4
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    pkt_arb_wrr_avlstrm_if.slave      bus,
    input  logic [NUM_IN*WW-1:0]      cfg_weight,
    output logic [$clog2(NUM_IN)-1:0] grant_idx,
    output logic                      sop_err
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [NUM_IN*32-1:0]      stat_pkt_cnt,
    output logic [31:0]               stat_sop_err_cnt
`endif
);
    localparam int IW = $clog2(NUM_IN);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [WW-1:0]     burst_q, burst_d;
    logic              sop_err_q, sop_err_d;

    logic [NUM_IN-1:0] cand_s;
    logic [NUM_IN-1:0] bad_s;
    logic [IW-1:0]     bad_idx_s;
    logic [IW-1:0]     rr_idx_s;
    logic              rr_found_s;
    logic [WW-1:0]     w_ptr_s;
    logic              keep_s;
    logic [IW-1:0]     win_s;
    logic              start_s;
    logic [NUM_IN-1:0] ready_s;
    logic              eop_fire_s;

    rr_pick_nxt #(.N(NUM_IN)) u_rr (
        .req_i   (cand_s),
        .ptr_i   (ptr_q),
        .idx_o   (rr_idx_s),
        .found_o (rr_found_s)
    );

    // Classify head beats: packet-start candidates and stray non-sop heads
    always_comb begin
        cand_s    = {NUM_IN{1'b0}};
        bad_s     = {NUM_IN{1'b0}};
        bad_idx_s = {IW{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            cand_s[i] = bus.in_valid[i] & bus.in_sop[i] &
                        (cfg_weight[i*WW +: WW] != {WW{1'b0}});
            bad_s[i]  = bus.in_valid[i] & ~bus.in_sop[i];
        end
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            bad_idx_s = bad_s[i] ? IW'(i) : bad_idx_s;
        end
    end

    // Pick the winner: the current owner keeps its turn while it has weight left
    always_comb begin
        w_ptr_s = cfg_weight[ptr_q*WW +: WW];
        keep_s  = cand_s[ptr_q] & (burst_q < w_ptr_s);
        win_s   = keep_s ? ptr_q : rr_idx_s;
        start_s = ~bus.out_almostfull & rr_found_s;
    end

    // FSM next state, ingress ready and egress data path
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        burst_d       = burst_q;
        sop_err_d     = 1'b0;
        ready_s       = {NUM_IN{1'b0}};
        eop_fire_s    = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = {DW{1'b0}};
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        bus.out_empty = {EW{1'b0}};
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    grant_d = win_s;
                    ptr_d   = win_s;
                    state_d = XFER;
                    // A new owner starts its turn from zero, so its first packet counts as one.
                    if (keep_s) begin
                        burst_d = (burst_q == {WW{1'b1}}) ? burst_q
                                                          : burst_q + {{(WW-1){1'b0}}, 1'b1};
                    end else begin
                        burst_d = {{(WW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = IDLE;
                end
                // Drop one stray mid-packet beat per cycle so it cannot block its input forever.
                if (|bad_s) begin
                    ready_s[bad_idx_s] = 1'b1;
                    sop_err_d          = 1'b1;
                end else begin
                    sop_err_d          = 1'b0;
                end
            end
            XFER: begin
                bus.out_valid    = bus.in_valid[grant_q];
                bus.out_data     = bus.in_data[grant_q*DW +: DW];
                bus.out_sop      = bus.in_sop[grant_q];
                bus.out_eop      = bus.in_eop[grant_q];
                bus.out_empty    = bus.in_empty[grant_q*EW +: EW];
                ready_s[grant_q] = bus.out_ready;
                eop_fire_s       = bus.in_valid[grant_q] & bus.out_ready & bus.in_eop[grant_q];
                if (eop_fire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ingress ready is held low while reset is asserted
    always_comb begin
        if (Rst_n) begin
            bus.in_ready = ready_s;
        end else begin
            bus.in_ready = {NUM_IN{1'b0}};
        end
    end

    // Arbiter state registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= {IW{1'b0}};
            grant_q   <= {IW{1'b0}};
            burst_q   <= {WW{1'b0}};
            sop_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            burst_q   <= burst_d;
            sop_err_q <= sop_err_d;
        end
    end

    assign grant_idx = grant_q;
    assign sop_err   = sop_err_q;

`ifdef PKT_ARB_STATS_EN
    logic [NUM_IN*32-1:0] pkt_cnt_q;
    logic [31:0]          err_cnt_q;

    // Per-input completed packet counters (wrapping) and saturating sop-error count
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pkt_cnt_q <= {(NUM_IN*32){1'b0}};
            err_cnt_q <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (eop_fire_s && (grant_q == IW'(i))) begin
                    pkt_cnt_q[i*32 +: 32] <= pkt_cnt_q[i*32 +: 32] + 32'd1;
                end else begin
                    pkt_cnt_q[i*32 +: 32] <= pkt_cnt_q[i*32 +: 32];
                end
            end
            if (sop_err_d && (err_cnt_q != 32'hFFFF_FFFF)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end

    assign stat_pkt_cnt     = pkt_cnt_q;
    assign stat_sop_err_cnt = err_cnt_q;
`endif

endmodule
